// File: rtl/axi4_slave_write_responder.sv
// AXI4 slave write endpoint: accepts AW/W, writes a byte-lane memory, returns B.
// Optional macro AXI4_WR_RESP_LATENCY_EN inserts a RESP_LATENCY-cycle WAIT before BVALID.
module axi4_slave_write_responder #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 32,
    parameter int ID_WIDTH     = 4,
    parameter int MEM_DEPTH    = 256,
    parameter int RESP_LATENCY = 4
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [ID_WIDTH-1:0]          awid,
    input  logic [ADDR_WIDTH-1:0]        awaddr,
    input  logic [7:0]                   awlen,
    input  logic [2:0]                   awsize,
    input  logic [1:0]                   awburst,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    input  logic                         wlast,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [ID_WIDTH-1:0]          bid,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_idx,
    output logic [DATA_WIDTH-1:0]        dbg_rdata
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int BSH    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_W);

`ifdef AXI4_WR_RESP_LATENCY_EN
    localparam int LAT_CYCLES = RESP_LATENCY;
`else
    // Latency parameter has no effect in this build; WAIT is unreachable.
    localparam int LAT_CYCLES = 0 * RESP_LATENCY;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic [ID_WIDTH-1:0]   id_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [7:0]            len_reg;
    logic [2:0]            size_reg;
    logic [1:0]            burst_reg;
    logic [7:0]            cnt_reg;
    logic                  ax_err_reg;
    logic                  dec_err_reg;
    logic                  last_err_reg;
    logic [1:0]            bresp_reg;
    logic [15:0]           lat_cnt_reg;

    logic                  aw_fire, w_fire, last_beat, beat_dec, mem_we;
    logic                  ax_err_in, dec_err_now, last_err_now;
    logic [1:0]            resp_final;
    logic [IDX_W-1:0]      mem_idx;
    logic [ADDR_WIDTH-1:0] incr, wrap_mask, addr_next;

    // Handshake readies and bvalid come straight from the state register.
    assign awready = (state_reg == S_IDLE);
    assign wready  = (state_reg == S_DATA);
    assign bvalid  = (state_reg == S_RESP);
    assign bid     = id_reg;
    assign bresp   = bresp_reg;

    assign aw_fire   = awvalid && (state_reg == S_IDLE);
    assign w_fire    = wvalid && (state_reg == S_DATA);
    assign last_beat = (cnt_reg == len_reg);
    assign beat_dec  = ({1'b0, addr_reg} >= MEM_BYTES);
    assign mem_we    = w_fire && !ax_err_reg && !dec_err_reg && !beat_dec;
    assign mem_idx   = addr_reg[BSH +: IDX_W];

    assign ax_err_in = (awburst == 2'b11)
                    || (32'(awsize) > BSH)
                    || ((awburst == 2'b10)
                        && (!(awlen inside {8'd1, 8'd3, 8'd7, 8'd15})
                            || ((awaddr & ((ADDR_WIDTH'(1) << awsize) - ADDR_WIDTH'(1))) != '0)));

    assign dec_err_now  = dec_err_reg || (w_fire && beat_dec);
    assign last_err_now = last_err_reg || (w_fire && (wlast != last_beat));
    assign resp_final   = dec_err_now ? 2'b11 :
                          (ax_err_reg || last_err_now) ? 2'b10 : 2'b00;

    assign incr      = ADDR_WIDTH'(1) << size_reg;
    assign wrap_mask = ((ADDR_WIDTH'(len_reg) + ADDR_WIDTH'(1)) << size_reg) - ADDR_WIDTH'(1);

    always_comb begin
        addr_next = addr_reg;
        case (burst_reg)
            2'b01:   addr_next = addr_reg + incr;
            2'b10:   addr_next = (addr_reg & ~wrap_mask) | ((addr_reg + incr) & wrap_mask);
            default: addr_next = addr_reg;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (aw_fire) state_next = S_DATA;
            S_DATA: begin
                if (w_fire && last_beat) begin
                    state_next = (LAT_CYCLES != 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: if (lat_cnt_reg == '0) state_next = S_RESP;
            S_RESP: if (bready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            id_reg       <= '0;
            addr_reg     <= '0;
            len_reg      <= '0;
            size_reg     <= '0;
            burst_reg    <= '0;
            cnt_reg      <= '0;
            ax_err_reg   <= 1'b0;
            dec_err_reg  <= 1'b0;
            last_err_reg <= 1'b0;
            bresp_reg    <= 2'b00;
            lat_cnt_reg  <= '0;
        end else begin
            if (aw_fire) begin
                id_reg       <= awid;
                addr_reg     <= awaddr;
                len_reg      <= awlen;
                size_reg     <= awsize;
                burst_reg    <= awburst;
                cnt_reg      <= '0;
                ax_err_reg   <= ax_err_in;
                dec_err_reg  <= 1'b0;
                last_err_reg <= 1'b0;
            end
            if (w_fire) begin
                cnt_reg      <= cnt_reg + 8'd1;
                addr_reg     <= addr_next;
                dec_err_reg  <= dec_err_now;
                last_err_reg <= last_err_now;
                if (last_beat) begin
                    bresp_reg   <= resp_final;
                    lat_cnt_reg <= 16'(LAT_CYCLES - 1);
                end
            end
            if (state_reg == S_WAIT && lat_cnt_reg != '0) begin
                lat_cnt_reg <= lat_cnt_reg - 16'd1;
            end
        end
    end

    // One narrow RAM per byte lane so each strobe bit owns its own write port.
    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_DEPTH];

            always_ff @(posedge aclk) begin
                if (mem_we && wstrb[gi]) begin
                    lane_mem[mem_idx] <= wdata[gi*8 +: 8];
                end
            end

            assign dbg_rdata[gi*8 +: 8] = lane_mem[dbg_idx];
        end
    endgenerate

endmodule

// File: tb/tb_axi4_slave_write_responder.sv
// Scoreboard bench for axi4_slave_write_responder (default build, no response latency).
module tb_axi4_slave_write_responder;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  dbg_idx;
    logic [63:0] dbg_rdata;

    axi4_slave_write_responder dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .awid      (awid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bid       (bid),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .dbg_idx   (dbg_idx),
        .dbg_rdata (dbg_rdata)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_mem(input string tag, input logic [7:0] idx, input logic [63:0] exp);
        dbg_idx = idx;
        #1;
        check(tag, dbg_rdata, exp);
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        awvalid = 1'b1;
        for (int n = 0; n < 50 && !awready; n++) tick();
        check("awready", awready, 1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        wdata = data; wstrb = strb; wlast = last;
        wvalid = 1'b1;
        for (int n = 0; n < 50 && !wready; n++) tick();
        check("wready", wready, 1);
        tick();
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic recv_b(input int hold);
        exp_t e;
        for (int n = 0; n < 50 && !bvalid; n++) tick();
        check("bvalid_wait", bvalid, 1);
        if (sb_q.size() == 0) begin
            check("sb_underflow", 1, 0);
        end else begin
            e = sb_q[0];
            for (int c = 0; c < hold; c++) begin
                tick();
                check("bvalid_hold", bvalid, 1);
                check("bid_hold", bid, e.id);
                check("bresp_hold", bresp, e.resp);
            end
            bready = 1'b1;
            e = sb_q.pop_front();
            check("bid", bid, e.id);
            check("bresp", bresp, e.resp);
            tick();
            bready = 1'b0;
            check("bvalid_drop", bvalid, 0);
            check("awready_back", awready, 1);
        end
    endtask

    task automatic burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] btype, input logic [63:0] base,
                         input logic [7:0] strb, input int last_idx, input logic [1:0] exp_resp,
                         input int hold);
        // A W beat offered in IDLE must be refused
        wvalid = 1'b1; wdata = 64'hBAD; wstrb = 8'hFF;
        tick();
        check("wready_idle", wready, 0);
        wvalid = 1'b0;
        sb_q.push_back('{id: id, resp: exp_resp});
        send_aw(id, addr, len, size, btype);
        check("wready_t1", wready, 1);
        for (int i = 0; i <= int'(len); i++) begin
            send_w(base + 64'(i), strb, i == last_idx);
        end
        check("bvalid_lat", bvalid, 1);
        recv_b(hold);
        $display("txn id=%0d addr=%h len=%0d burst=%b expected bresp=%b",
                 id, addr, len, btype, exp_resp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; dbg_idx = '0;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        #1;
        check("rst_awready", awready, 1);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_bid", bid, 0);
        check("rst_bresp", bresp, 0);
        tick();

        // INCR, 4 beats at 0x100
        burst(4'd5, 32'h100, 8'd3, 3'd3, 2'b01, 64'd1, 8'hFF, 3, 2'b00, 0);
        check_mem("incr_w20", 8'h20, 64'd1);
        check_mem("incr_w21", 8'h21, 64'd2);
        check_mem("incr_w22", 8'h22, 64'd3);
        check_mem("incr_w23", 8'h23, 64'd4);

        // WRAP from 0x18 over a 32-byte block: words 3,0,1,2
        burst(4'd6, 32'h18, 8'd3, 3'd3, 2'b10, 64'h10, 8'hFF, 3, 2'b00, 0);
        check_mem("wrap_w3", 8'd3, 64'h10);
        check_mem("wrap_w0", 8'd0, 64'h11);
        check_mem("wrap_w1", 8'd1, 64'h12);
        check_mem("wrap_w2", 8'd2, 64'h13);

        // Reserved burst type: beats accepted, memory untouched
        burst(4'd2, 32'h100, 8'd1, 3'd3, 2'b11, 64'hAA, 8'hFF, 1, 2'b10, 0);
        check_mem("rsv_w20", 8'h20, 64'd1);
        check_mem("rsv_w21", 8'h21, 64'd2);

        // Second beat runs past the top of memory
        burst(4'd3, 32'h7F8, 8'd1, 3'd3, 2'b01, 64'h55, 8'hFF, 1, 2'b11, 0);
        check_mem("dec_w255", 8'd255, 64'h55);
        check_mem("dec_w0_alias", 8'd0, 64'h11);

        // Early wlast, slow bready
        burst(4'd4, 32'h200, 8'd2, 3'd3, 2'b01, 64'h30, 8'hFF, 1, 2'b10, 5);
        check_mem("wlast_w40", 8'h40, 64'h30);
        check_mem("wlast_w41", 8'h41, 64'h31);
        check_mem("wlast_w42", 8'h42, 64'h32);

        // Reset in the middle of a burst
        send_aw(4'd7, 32'h300, 8'd3, 3'd3, 2'b01);
        send_w(64'h1111_1111_1111_1111, 8'hFF, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        check("midrst_awready", awready, 1);
        check("midrst_wready", wready, 0);
        check("midrst_bvalid", bvalid, 0);
        tick();
        aresetn = 1'b1;
        tick();
        $display("txn id=7 addr=00000300 aborted by reset");

        // Partial-strobe write after reset completes OKAY
        burst(4'd9, 32'h300, 8'd0, 3'd3, 2'b01, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 0, 2'b00, 0);
        check_mem("strb_w60", 8'h60, 64'h1111_1111_CAFE_F00D);

        check("sb_empty", 64'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
